// File: rtl/beacon_pulse_detector.sv
// beacon_pulse_detector: debounces the beacon envelope on timebase ticks, times on-length and rising-to-rising period, and emits validated records over valid/ready (optional lost_o timeout via BEACON_DET_TIMEOUT_EN)
module beacon_pulse_detector #(
  parameter int CNT_W      = 16,
  parameter int DEBOUNCE   = 2,
  parameter int MIN_ON     = 50,
  parameter int MAX_ON     = 400,
  parameter int MIN_PERIOD = 700,
  parameter int MAX_PERIOD = 1300
`ifdef BEACON_DET_TIMEOUT_EN
  , parameter int LOST_TICKS = 4000
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             env_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] on_len_o,
  output logic [CNT_W-1:0] period_o,
  output logic             overrun_o
`ifdef BEACON_DET_TIMEOUT_EN
  , output logic           lost_o
`endif
);
  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
  localparam int RUN_W = $clog2(DEBOUNCE + 1);
  localparam logic [RUN_W-1:0] DEB_C = RUN_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_ON_C = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] MAX_ON_C = CNT_W'(MAX_ON);
  localparam logic [CNT_W-1:0] MIN_PER_C = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_PER_C = CNT_W'(MAX_PERIOD);
  state_t state, state_nx;
  logic lvl, lvl_nx, flip, rise, fall, emit;
  logic [RUN_W-1:0] run, run_nx;
  logic [CNT_W-1:0] on_cnt, per_cnt, on_inc, per_inc, on_len, on_len_nx;
  // debounce: a level change needs DEBOUNCE consecutive mismatching ticks
  always_comb begin
    flip = tick_i && (env_i != lvl) && (run + 1'b1 >= DEB_C);
    run_nx = !tick_i ? run : ((env_i == lvl) || flip) ? '0 : run + 1'b1;
    lvl_nx = flip ? env_i : lvl;
    rise = flip && env_i;
    fall = flip && !env_i;
    on_inc = (on_cnt == CNT_MAX) ? on_cnt : on_cnt + 1'b1;
    per_inc = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + 1'b1;
  end
  // pulse FSM: the counts seen on an event tick include that tick
  always_comb begin
    state_nx = state;
    on_len_nx = on_len;
    emit = 1'b0;
    if (tick_i) begin
      case (state)
        IDLE: state_nx = rise ? ON : IDLE;
        ON: begin
          if (fall) begin
            on_len_nx = on_inc;
            state_nx = (on_inc >= MIN_ON_C && on_inc <= MAX_ON_C) ? OFF : IDLE;
          end else if (on_inc > MAX_ON_C) state_nx = IDLE;
        end
        OFF: begin
          if (rise) begin
            emit = per_inc >= MIN_PER_C && per_inc <= MAX_PER_C;
            state_nx = ON;
          end else if (per_inc > MAX_PER_C) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end
  // state, debounce and tick counters advance only on ticks; both counters restart at a rise
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      lvl <= 1'b0;
      run <= '0;
      on_cnt <= '0;
      per_cnt <= '0;
      on_len <= '0;
    end else begin
      state <= state_nx;
      lvl <= lvl_nx;
      run <= run_nx;
      on_len <= on_len_nx;
      if (tick_i) begin
        on_cnt <= rise ? '0 : on_inc;
        per_cnt <= rise ? '0 : per_inc;
      end
    end
  end
  // output record register: a new emit always wins, overrun flags an unconsumed record being replaced
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_o <= 1'b0;
      overrun_o <= 1'b0;
      on_len_o <= '0;
      period_o <= '0;
    end else begin
      valid_o <= emit || (valid_o && !ready_i);
      overrun_o <= emit && valid_o && !ready_i;
      if (emit) begin
        on_len_o <= on_len;
        period_o <= per_inc;
      end
    end
  end
`ifdef BEACON_DET_TIMEOUT_EN
  localparam int LOST_W = $clog2(LOST_TICKS + 1);
  localparam logic [LOST_W-1:0] LOST_C = LOST_W'(LOST_TICKS);
  logic [LOST_W-1:0] lost_cnt;
  // ticks since the last emitted record, saturating at the loss threshold
  always_ff @(posedge clk) begin
    if (!rst || emit) lost_cnt <= '0;
    else if (tick_i && lost_cnt != LOST_C) lost_cnt <= lost_cnt + 1'b1;
  end
  assign lost_o = lost_cnt == LOST_C;
`endif
endmodule
